ps2_keycode_queue: RTL and testbench
====================================

# ps2_keycode_queue

Parametrised successor to the fixed three-byte keycode capture stage. Sits between the PS/2 receiver (irq/keycode/clear_keycode handshake) and the consumer: the 7-segment display path and the future CPU MMIO port. Decodes scan-code set 2 prefixes (E0 extended, F0 break) into single key events, buffers them in a DEPTH-entry FIFO with a valid/ready pop port, and exposes a raw-byte history of HIST bytes for display.

## Interface
- DEPTH, 8: event FIFO entries; power of two, ≥2.
- HIST, 3: raw-byte history length; ≥1.

- clock  in  1  single clock; all logic on negedge clock.
- reset  in  1  asynchronous, active-high.
- irq  in  1  receiver has a byte on keycode.
- keycode  in  8  received raw byte.
- clear_keycode  out  1  acknowledge to receiver; reset 0.
- ev_valid  out  1  FIFO head valid; reset 0.
- ev_ready  in  1  consumer pops head when ev_valid & ev_ready.
- ev_code  out  8  head code byte (prefixes stripped); reset 8'h00.
- ev_ext  out  1  head had E0 prefix; reset 0.
- ev_break  out  1  head had F0 prefix; reset 0.
- count  out  $clog2(DEPTH)+1  FIFO occupancy; reset 0.
- overflow  out  1  sticky: event lost to full FIFO; reset 0.
- ovf_clr  in  1  clears overflow (set wins if same cycle).
- hist  out  8*HIST  raw bytes, [7:0] newest; reset all 8'h00.

## Operation
- Byte acceptance: on edge with irq=1 and clear_keycode=0, byte captured, hist shifts (newest at [7:0]), clear_keycode set to 1. clear_keycode stays 1 while irq=1; returns to 0 on first edge with irq=0. Exactly one byte per irq assertion.
- Bytes 8'h00 and 8'hFF (receiver error/overrun): recorded in hist, no event, parser forced to IDLE.
- Parser FSM, acting on each accepted byte:
  - IDLE: E0→EXT; F0→BRK; other→emit {ext=0,brk=0}, stay IDLE.
  - EXT: F0→EXT_BRK; E0→EXT; other→emit {ext=1,brk=0}, →IDLE.
  - BRK: E0→EXT_BRK; F0→BRK; other→emit {ext=0,brk=1}, →IDLE.
  - EXT_BRK: E0/F0→EXT_BRK; other→emit {ext=1,brk=1}, →IDLE.
- Emit = FIFO push. Pop when ev_valid & ev_ready; FIFO is first-word-fall-through.
- Full, push, no pop: event dropped, overflow←1, count stays DEPTH.
- Full, push and pop same edge: both succeed, count unchanged, no overflow.
- Empty: ev_ready ignored; ev_code/ev_ext/ev_break hold last value.
- count wraps never; pointers are $clog2(DEPTH) bits, wrap modulo DEPTH.
- Reset mid-handshake or mid-prefix: FIFO emptied, parser IDLE, clear_keycode 0; an irq still high after reset is accepted as a new byte.

## Timing
- Edge N: byte captured, hist updated, clear_keycode=1.
- Edge N+1: parser transition and FIFO push; ev_valid=1 after N+1 if FIFO was empty. Latency irq-sample → ev_valid: 2 edges.
- Pop at edge M: next entry (or ev_valid=0) visible after M.
- Max accept rate one byte per 2 edges (handshake); FIFO sustains one push and one pop per edge.

## Configuration
- PS2_KEYQ_TYPEMATIC_FILTER_EN defined: block keeps last_make {valid, ext, code}. Make event equal in ext+code to last_make with valid=1 is discarded (not counted as overflow). Any make sets last_make; break with matching ext+code clears valid; reset clears valid.
- Undefined: every make, including typematic repeats, is pushed. No last_make register.

## Structure
- Package ps2_pkg: PS2_EXT_PREFIX=8'hE0, PS2_BRK_PREFIX=8'hF0, PS2_ERR_LO=8'h00, PS2_ERR_HI=8'hFF; typedef ps2_event_t packed {ext, brk, code[7:0]}; typedef enum ps2_parse_state_t {IDLE, EXT, BRK, EXT_BRK}.
- Sub-module ps2_event_fifo: parametrised DEPTH synchronous FIFO of ps2_event_t with push/pop/full/empty/count; parser and handshake stay in the top.

## Test plan
- Reset release, no irq → clear_keycode=0, ev_valid=0, count=0, hist=0.
- Bytes 1C, F0, 1C → events {1C,ext0,brk0},{1C,ext0,brk1}; hist = {1C,F0,1C} newest at [7:0].
- Bytes E0, F0, 75 → one event {75,ext1,brk1}; count=1; ev_valid 2 edges after the 75 sample.
- ev_ready=0, push DEPTH+1 makes (distinct codes) → count=DEPTH, overflow=1, head = first code; ovf_clr → overflow=0.
- FIFO full, push and pop same edge → count stays DEPTH, overflow stays 0, new tail present.
- Bytes 1C,1C,1C,F0,1C,1C with filter macro → events make1C, break1C, make1C (3 total); without macro → 5 events.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keycode queue: scan-code set 2
// prefixes, receiver error bytes, event record and parser states.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_ERR_LO     = 8'h00;
    localparam logic [7:0] PS2_ERR_HI     = 8'hFF;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int PS2_EVENT_W = $bits(ps2_event_t);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} ps2_parse_state_t;

    function automatic logic ps2_is_err(input logic [7:0] b);
        return (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO of packed ps2_event_t records. The head output
// holds the last valid entry once the FIFO drains.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [PS2_EVENT_W-1:0]   din,
    input  logic                     pop,
    output logic [PS2_EVENT_W-1:0]   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [PS2_EVENT_W-1:0] mem [DEPTH];
    logic [PS2_EVENT_W-1:0] hold;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? hold : mem[rd_ptr];

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (!empty) hold <= mem[rd_ptr];
        end
    end

    always_ff @(negedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_keycode_queue.sv
// PS/2 receiver handshake, scan-code set 2 prefix parser and event queue.
// Optional PS2_KEYQ_TYPEMATIC_FILTER_EN drops repeated make events.
module ps2_keycode_queue
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int HIST  = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   irq,
    input  logic [7:0]             keycode,
    output logic                   clear_keycode,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [7:0]             ev_code,
    output logic                   ev_ext,
    output logic                   ev_break,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [8*HIST-1:0]      hist
);

    ps2_parse_state_t state, state_n;
    logic [7:0]       byte_q;
    logic             byte_vld;
    logic             emit;
    logic             push;
    logic             full;
    logic             empty;
    logic             pop;
    ps2_event_t       ev_in;
    ps2_event_t       ev_out;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            clear_keycode <= 1'b0;
            hist          <= '0;
            byte_q        <= '0;
            byte_vld      <= 1'b0;
            state         <= IDLE;
        end else begin
            // Acknowledge follows irq, so one byte is taken per irq pulse.
            clear_keycode <= irq;
            byte_vld      <= irq & ~clear_keycode;
            if (irq && !clear_keycode) begin
                byte_q <= keycode;
                hist   <= (8*HIST)'({hist, keycode});
            end
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        emit       = 1'b0;
        ev_in.ext  = 1'b0;
        ev_in.brk  = 1'b0;
        ev_in.code = byte_q;
        if (byte_vld) begin
            if (ps2_is_err(byte_q)) begin
                state_n = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (byte_q == PS2_EXT_PREFIX)      state_n = EXT;
                        else if (byte_q == PS2_BRK_PREFIX) state_n = BRK;
                        else emit = 1'b1;
                    end
                    EXT: begin
                        if (byte_q == PS2_BRK_PREFIX)      state_n = EXT_BRK;
                        else if (byte_q == PS2_EXT_PREFIX) state_n = EXT;
                        else begin
                            emit = 1'b1; ev_in.ext = 1'b1; state_n = IDLE;
                        end
                    end
                    BRK: begin
                        if (byte_q == PS2_EXT_PREFIX)      state_n = EXT_BRK;
                        else if (byte_q == PS2_BRK_PREFIX) state_n = BRK;
                        else begin
                            emit = 1'b1; ev_in.brk = 1'b1; state_n = IDLE;
                        end
                    end
                    default: begin
                        if (byte_q != PS2_EXT_PREFIX && byte_q != PS2_BRK_PREFIX) begin
                            emit = 1'b1; ev_in.ext = 1'b1; ev_in.brk = 1'b1;
                            state_n = IDLE;
                        end
                    end
                endcase
            end
        end
    end

`ifdef PS2_KEYQ_TYPEMATIC_FILTER_EN
    logic       lm_valid;
    logic       lm_ext;
    logic [7:0] lm_code;
    logic       lm_match;

    assign lm_match = lm_valid && (lm_ext == ev_in.ext) && (lm_code == ev_in.code);
    assign push     = emit & ~(~ev_in.brk & lm_match);

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            lm_valid <= 1'b0;
            lm_ext   <= 1'b0;
            lm_code  <= '0;
        end else if (emit) begin
            if (!ev_in.brk) begin
                lm_valid <= 1'b1;
                lm_ext   <= ev_in.ext;
                lm_code  <= ev_in.code;
            end else if (lm_match) begin
                lm_valid <= 1'b0;
            end
        end
    end
`else
    assign push = emit;
`endif

    assign pop      = ev_valid & ev_ready;
    assign ev_valid = ~empty;
    assign ev_code  = ev_out.code;
    assign ev_ext   = ev_out.ext;
    assign ev_break = ev_out.brk;

    always_ff @(negedge clock or posedge reset) begin
        if (reset)                    overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
        else if (ovf_clr)             overflow <= 1'b0;
    end

    ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (ev_in),
        .pop   (pop),
        .dout  (ev_out),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_ps2_keycode_queue.sv
// Self-checking bench for ps2_keycode_queue: byte table, scoreboard of events,
// and hand-driven latency, overflow, typematic and reset sequences.
module tb_ps2_keycode_queue;

    localparam int DEPTH = 8;
    localparam int HIST  = 3;
    localparam int HW    = 8*HIST;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   irq;
    logic [7:0]             keycode;
    logic                   clear_keycode;
    logic                   ev_valid;
    logic                   ev_ready;
    logic [7:0]             ev_code;
    logic                   ev_ext;
    logic                   ev_break;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   ovf_clr;
    logic [HW-1:0]          hist;

    ps2_keycode_queue #(.DEPTH(DEPTH), .HIST(HIST)) dut (
        .clock(clock), .reset(reset), .irq(irq), .keycode(keycode),
        .clear_keycode(clear_keycode), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .count(count),
        .overflow(overflow), .ovf_clr(ovf_clr), .hist(hist)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    typedef struct {
        logic [7:0] kc;
        bit         emit;
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } vec_t;

    ev_t           sb[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_pops   = 0;
    logic [HW-1:0] hist_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DUT acts on negedge; the bench drives just after it and samples mid-cycle.
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    always @(posedge clock) begin
        if (!reset && ev_valid && ev_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_event: got %0h ext %0b brk %0b, none expected",
                         ev_code, ev_ext, ev_break);
            end else begin
                ev_t e;
                e = sb.pop_front();
                n_pops++;
                if ({ev_code, ev_ext, ev_break} !== {e.code, e.ext, e.brk}) begin
                    n_errors++;
                    $display("FAIL event: got %0h ext %0b brk %0b expected %0h ext %0b brk %0b",
                             ev_code, ev_ext, ev_break, e.code, e.ext, e.brk);
                end
            end
        end
    end

    task automatic expect_ev(input logic [7:0] c, input logic x, input logic b);
        ev_t e;
        e.code = c; e.ext = x; e.brk = b;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        step();
        irq = 1'b1;
        keycode = b;
        hist_m = HW'({hist_m, b});
        for (int i = 0; i < 8; i++) begin
            step();
            if (clear_keycode) break;
        end
        chk("ack_rise", clear_keycode, 1'b1);
        irq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (!clear_keycode) break;
        end
        chk("ack_fall", clear_keycode, 1'b0);
        chk("hist", hist, hist_m);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        step();
        sb.delete();
        hist_m = '0;
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        ev_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sb.size() == 0 && !ev_valid) break;
        end
        repeat (3) step();
        chk({name, "_left"}, sb.size(), 0);
        chk({name, "_valid"}, ev_valid, 1'b0);
        chk({name, "_count"}, count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[18];
        int   exp_pops;

        tbl = '{
            '{8'h1C, 1, 8'h1C, 0, 0}, '{8'hF0, 0, 8'h00, 0, 0},
            '{8'h1C, 1, 8'h1C, 0, 1}, '{8'hE0, 0, 8'h00, 0, 0},
            '{8'hF0, 0, 8'h00, 0, 0}, '{8'h75, 1, 8'h75, 1, 1},
            '{8'hE0, 0, 8'h00, 0, 0}, '{8'h74, 1, 8'h74, 1, 0},
            '{8'hF0, 0, 8'h00, 0, 0}, '{8'hE0, 0, 8'h00, 0, 0},
            '{8'h6B, 1, 8'h6B, 1, 1}, '{8'hE0, 0, 8'h00, 0, 0},
            '{8'h00, 0, 8'h00, 0, 0}, '{8'h29, 1, 8'h29, 0, 0},
            '{8'hFF, 0, 8'h00, 0, 0}, '{8'hF0, 0, 8'h00, 0, 0},
            '{8'hFF, 0, 8'h00, 0, 0}, '{8'h5A, 1, 8'h5A, 0, 0}
        };

        reset = 1'b1; irq = 1'b0; keycode = 8'h00; ev_ready = 1'b0; ovf_clr = 1'b0;
        hist_m = '0;
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        chk("rst_clear", clear_keycode, 1'b0);
        chk("rst_valid", ev_valid, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_hist", hist, 0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_head", {ev_code, ev_ext, ev_break}, 10'h000);

        // Byte table with the consumer always ready.
        ev_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].emit) expect_ev(tbl[i].code, tbl[i].ext, tbl[i].brk);
            send_byte(tbl[i].kc);
            if (i == 2) chk("hist_1c_f0_1c", hist, 24'h1CF01C);
        end
        drain("table");
        chk("table_ovf", overflow, 1'b0);

        // Latency: event visible two edges after the final byte is sampled.
        do_reset();
        ev_ready = 1'b0;
        send_byte(8'hE0);
        send_byte(8'hF0);
        step();
        irq = 1'b1; keycode = 8'h75;
        hist_m = HW'({hist_m, 8'h75});
        expect_ev(8'h75, 1'b1, 1'b1);
        step();
        chk("lat_edge_n", ev_valid, 1'b0);
        step();
        chk("lat_edge_n1", ev_valid, 1'b1);
        chk("lat_count", count, 1);
        chk("lat_head", {ev_code, ev_ext, ev_break}, {8'h75, 2'b11});
        irq = 1'b0;
        step();
        chk("lat_hist", hist, hist_m);
        drain("lat");

        // Overflow: DEPTH+1 makes with the consumer stalled.
        do_reset();
        ev_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) expect_ev(8'h10 + 8'(i), 1'b0, 1'b0);
            send_byte(8'h10 + 8'(i));
        end
        chk("ovf_count", count, DEPTH);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_head", ev_code, 8'h10);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 1'b0);

        // Full FIFO: push and pop on the same edge.
        irq = 1'b1; keycode = 8'h19;
        hist_m = HW'({hist_m, 8'h19});
        expect_ev(8'h19, 1'b0, 1'b0);
        step();
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        chk("pp_count", count, DEPTH);
        chk("pp_ovf", overflow, 1'b0);
        irq = 1'b0;
        step();
        chk("pp_hist", hist, hist_m);
        drain("pp");
        chk("hold_code", ev_code, 8'h19);

        // Typematic repeats.
        do_reset();
        ev_ready = 1'b1;
        exp_pops = n_pops;
`ifdef PS2_KEYQ_TYPEMATIC_FILTER_EN
        expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b1);
        expect_ev(8'h1C, 1'b0, 1'b0);
        exp_pops += 3;
`else
        for (int i = 0; i < 3; i++) expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b1);
        expect_ev(8'h1C, 1'b0, 1'b0);
        exp_pops += 5;
`endif
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
        drain("typ");
        chk("typ_events", n_pops, exp_pops);

        // Reset mid-prefix and mid-handshake; held irq becomes a fresh byte.
        do_reset();
        ev_ready = 1'b0;
        send_byte(8'hE0);
        step();
        irq = 1'b1; keycode = 8'h2A;
        step();
        chk("mid_ack", clear_keycode, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ack", clear_keycode, 1'b0);
        step();
        chk("mid_rst_hist", hist, 0);
        sb.delete();
        hist_m = HW'({24'h0, 8'h2A});
        expect_ev(8'h2A, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk("mid_reaccept", clear_keycode, 1'b1);
        irq = 1'b0;
        step();
        chk("mid_hist", hist, hist_m);
        drain("mid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
